memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 230 +++++++++++++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Pipeline MEM stage: internal 2^ADDR_W x 16 data memory, stack pointer, two-word PC push/pop FSM.
// Optional stack over/underflow guard enabled by defining STACK_GUARD_EN.
module memory_stage #(
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       result,
    input  logic [15:0]       read_data1,
    input  logic [15:0]       read_data2,
    input  logic [31:0]       pc_plus_one,
    input  logic [2:0]        flag_register,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              mem_push,
    input  logic              mem_pop,
    input  logic [1:0]        memory_address_select,
    input  logic [1:0]        memory_write_src_select,
    input  logic              pc_choose_memory,
    input  logic              reg_write,
    input  logic [1:0]        wb_sel,
    input  logic [2:0]        reg_write_address,
    input  logic              outport_enable,
    output logic [15:0]       mem_data_out,
    output logic [15:0]       result_out,
    output logic              reg_write_out,
    output logic [1:0]        wb_sel_out,
    output logic [2:0]        reg_write_address_out,
    output logic              outport_enable_out,
    output logic              stall_out,
    output logic [31:0]       new_pc_out,
    output logic              pc_load_out,
    output logic [ADDR_W-1:0] sp_out,
    output logic              stack_fault
);

    localparam int unsigned DW    = 16;
    localparam int unsigned PCW   = 32;
    localparam int unsigned DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, PUSH_LO, POP_HI} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sp_q, sp_d, sp_inc, sp_dec, addr_sel;
    logic [DW-1:0]     hold_q, hold_d;
    logic [DW-1:0]     mem_data_q, mem_data_d;
    logic [PCW-1:0]    new_pc_q, new_pc_d;
    logic              pc_load_q, pc_load_d;
    logic [DW-1:0]     result_q;
    logic              reg_write_q, outport_q;
    logic [1:0]        wb_sel_q;
    logic [2:0]        rwa_q;

    logic [DW-1:0]     mem [DEPTH];
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DW-1:0]     mem_wdata, src_data, mem_sp1;

    logic push, pop, conflict, push_two, pop_two;
    logic push_blk, pop_blk, bubble, stall_c;

    assign sp_inc   = sp_q + ADDR_W'(1);
    assign sp_dec   = sp_q - ADDR_W'(1);
    assign mem_sp1  = mem[sp_inc];
    assign push     = mem_push & ~mem_pop;
    assign pop      = mem_pop & ~mem_push;
    assign conflict = mem_push & mem_pop;
    assign push_two = push & (memory_write_src_select == 2'b10);
    assign pop_two  = pop & pc_choose_memory;

    // Address and write-data source selection
    always_comb begin
        case (memory_address_select)
            2'b01:   addr_sel = sp_q;
            2'b10:   addr_sel = sp_inc;
            default: addr_sel = result[ADDR_W-1:0];
        endcase
        case (memory_write_src_select)
            2'b00:   src_data = read_data2;
            2'b01:   src_data = read_data1;
            2'b10:   src_data = pc_plus_one[15:0];
            default: src_data = {13'b0, flag_register};
        endcase
    end

`ifdef STACK_GUARD_EN
    localparam int unsigned AW1 = ADDR_W + 1;
    logic [AW1-1:0] sp_ext, push_words, pop_words;
    logic           fault_q;

    assign sp_ext     = {1'b0, sp_q};
    assign push_words = push_two ? AW1'(2) : AW1'(1);
    assign pop_words  = pop_two  ? AW1'(2) : AW1'(1);
    assign push_blk   = (sp_ext + AW1'(1)) < push_words;
    assign pop_blk    = (sp_ext + pop_words) > {1'b0, {ADDR_W{1'b1}}};

    // Sticky fault, only a fresh operation in IDLE can trip it
    always_ff @(posedge clk) begin
        if (reset)
            fault_q <= 1'b0;
        else if (state_q == IDLE && ((push && push_blk) || (pop && pop_blk)))
            fault_q <= 1'b1;
    end
    assign stack_fault = fault_q;
`else
    assign push_blk    = 1'b0;
    assign pop_blk     = 1'b0;
    assign stack_fault = 1'b0;
`endif

    // Next-state, memory access and bubble control
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        hold_d     = hold_q;
        mem_data_d = mem_data_q;
        new_pc_d   = new_pc_q;
        pc_load_d  = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = sp_q;
        mem_wdata  = src_data;
        bubble     = 1'b0;
        stall_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (conflict) begin
                    bubble = 1'b1;
                end else if (push) begin
                    if (push_blk) begin
                        bubble = 1'b1;
                    end else begin
                        mem_we = 1'b1;
                        sp_d   = sp_dec;
                        if (push_two) begin
                            mem_wdata = pc_plus_one[31:16];
                            hold_d    = pc_plus_one[15:0];
                            stall_c   = 1'b1;
                            bubble    = 1'b1;
                            state_d   = PUSH_LO;
                        end
                    end
                end else if (pop) begin
                    if (pop_blk) begin
                        bubble = 1'b1;
                    end else begin
                        sp_d = sp_inc;
                        if (pop_two) begin
                            hold_d  = mem_sp1;
                            stall_c = 1'b1;
                            bubble  = 1'b1;
                            state_d = POP_HI;
                        end else begin
                            mem_data_d = mem_sp1;
                        end
                    end
                end else begin
                    if (mem_write) begin
                        mem_we    = 1'b1;
                        mem_waddr = addr_sel;
                    end
                    if (mem_read)
                        mem_data_d = mem[addr_sel];
                end
            end
            PUSH_LO: begin
                mem_we    = 1'b1;
                mem_wdata = hold_q;
                sp_d      = sp_dec;
                state_d   = IDLE;
            end
            POP_HI: begin
                sp_d      = sp_inc;
                new_pc_d  = {mem_sp1, hold_q};
                pc_load_d = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Reset abandons any in-flight access; memory contents are kept
        if (reset) begin
            mem_we  = 1'b0;
            stall_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sp_q        <= {ADDR_W{1'b1}};
            hold_q      <= '0;
            mem_data_q  <= '0;
            new_pc_q    <= '0;
            pc_load_q   <= 1'b0;
            result_q    <= '0;
            reg_write_q <= 1'b0;
            outport_q   <= 1'b0;
            wb_sel_q    <= '0;
            rwa_q       <= '0;
        end else begin
            state_q     <= state_d;
            sp_q        <= sp_d;
            hold_q      <= hold_d;
            mem_data_q  <= mem_data_d;
            new_pc_q    <= new_pc_d;
            pc_load_q   <= pc_load_d;
            result_q    <= result;
            reg_write_q <= reg_write & ~bubble;
            outport_q   <= outport_enable & ~bubble;
            wb_sel_q    <= wb_sel;
            rwa_q       <= reg_write_address;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    assign mem_data_out          = mem_data_q;
    assign result_out            = result_q;
    assign reg_write_out         = reg_write_q;
    assign wb_sel_out            = wb_sel_q;
    assign reg_write_address_out = rwa_q;
    assign outport_enable_out    = outport_q;
    assign stall_out             = stall_c;
    assign new_pc_out            = new_pc_q;
    assign pc_load_out           = pc_load_q;
    assign sp_out                = sp_q;

endmodule
